// File: rtl/btb_upd_ctrl.sv
// sync_fifo: small first-in first-out store with a synchronous clear.
// Latency: the head is visible combinationally; a push shows up at the head one cycle later.
// Backpressure: full/empty flags; a push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdat,
    input  logic         pop,
    output logic [W-1:0] rdat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(D);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(D);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & ~empty & ~clr;
    assign rdat    = mem[rd_ptr];

    // Pointers and occupancy; clear discards all stored entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end
endmodule

// btb_upd_ctrl: serializes commit training events onto the BTB training port; sequences invalidate sweeps.
// Latency: bypass 1 cycle commit-to-strobe; queued entries drain one per cycle; a sweep lasts BTB_D cycles.
// Backpressure: upd_stall while the FIFO is full (events then are dropped); training held off during a sweep.
// Build option: define BTB_JUMP_FILTER_EN to discard correctly predicted jumps before they are queued.
module btb_upd_ctrl #(
    parameter int ADDR   = 32,
    parameter int BTB_D  = 32,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     br_commit_,
    input  logic                     br_taken_,
    input  logic                     br_miss_,
    input  logic                     jump_commit_,
    input  logic                     jump_miss_,
    input  logic [ADDR-1:0]          com_addr,
    input  logic [ADDR-1:0]          com_tar_addr,
    input  logic                     inv_req_,
    output logic                     upd_stall,
    output logic                     sweep_busy,
    output logic                     btb_br_commit_,
    output logic                     btb_br_taken_,
    output logic                     btb_br_miss_,
    output logic                     btb_jump_commit_,
    output logic                     btb_jump_miss_,
    output logic [ADDR-1:0]          btb_com_addr,
    output logic [ADDR-1:0]          btb_com_tar_addr,
    output logic                     btb_inv_,
    output logic [$clog2(BTB_D)-1:0] btb_inv_idx
);
    localparam int IW = $clog2(BTB_D);
    localparam logic [IW-1:0] LAST_IDX = IW'(BTB_D - 1);

    typedef enum logic {RUN = 1'b0, SWEEP = 1'b1} state_t;

    typedef struct packed {
        logic            jump;
        logic            taken_;
        logic            miss_;
        logic [ADDR-1:0] addr;
        logic [ADDR-1:0] tar;
    } entry_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] sweep_idx;
    entry_t        ev_dat;
    entry_t        head_dat;
    entry_t        issue_dat;
    logic          ev_vld;
    logic          push;
    logic          pop;
    logic          issue_vld;
    logic          fifo_clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          inv_req;

    assign inv_req     = ~inv_req_;
    assign upd_stall   = fifo_full;
    assign sweep_busy  = (state == SWEEP);
    assign btb_inv_    = (state != SWEEP);
    assign btb_inv_idx = sweep_idx;

`ifdef BTB_JUMP_FILTER_EN
    // Correctly predicted jumps teach the BTB nothing; drop them before they take FIFO space.
    assign ev_vld = ~br_commit_ | (~jump_commit_ & ~jump_miss_);
`else
    assign ev_vld = ~br_commit_ | ~jump_commit_;
`endif

    // Pack the incoming commit into a queue entry; a jump carries no taken flag.
    always_comb begin
        ev_dat.jump   = br_commit_;
        ev_dat.taken_ = br_commit_ ? 1'b1 : br_taken_;
        ev_dat.miss_  = br_commit_ ? jump_miss_ : br_miss_;
        ev_dat.addr   = com_addr;
        ev_dat.tar    = com_tar_addr;
    end

    sync_fifo #(
        .W ($bits(entry_t)),
        .D (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (fifo_clr),
        .push  (push),
        .wdat  (ev_dat),
        .pop   (pop),
        .rdat  (head_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Next state and queue control: invalidate wins, sweep only queues, run drains before bypassing.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        issue_vld = 1'b0;
        fifo_clr  = 1'b0;
        if (inv_req) begin
            state_nxt = SWEEP;
            fifo_clr  = 1'b1;
        end else if (state == SWEEP) begin
            push = ev_vld & ~fifo_full;
            if (sweep_idx == LAST_IDX) state_nxt = RUN;
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            issue_vld = 1'b1;
            push      = ev_vld & ~fifo_full;
        end else begin
            issue_vld = ev_vld;
        end
    end

    assign issue_dat = pop ? head_dat : ev_dat;

    // Sweep index: restarts on every invalidate request, steps once per sweep cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               sweep_idx <= '0;
        else if (inv_req)        sweep_idx <= '0;
        else if (state == SWEEP) sweep_idx <= sweep_idx + 1'b1;
    end

    // BTB training registers: strobes are idle unless an entry issues this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_br_commit_   <= 1'b1;
            btb_br_taken_    <= 1'b1;
            btb_br_miss_     <= 1'b1;
            btb_jump_commit_ <= 1'b1;
            btb_jump_miss_   <= 1'b1;
            btb_com_addr     <= '0;
            btb_com_tar_addr <= '0;
        end else begin
            btb_br_commit_   <= ~(issue_vld & ~issue_dat.jump);
            btb_br_taken_    <= ~(issue_vld & ~issue_dat.jump) | issue_dat.taken_;
            btb_br_miss_     <= ~(issue_vld & ~issue_dat.jump) | issue_dat.miss_;
            btb_jump_commit_ <= ~(issue_vld & issue_dat.jump);
            btb_jump_miss_   <= ~(issue_vld & issue_dat.jump) | issue_dat.miss_;
            if (issue_vld) begin
                btb_com_addr     <= issue_dat.addr;
                btb_com_tar_addr <= issue_dat.tar;
            end
        end
    end
endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Bench for btb_upd_ctrl: directed table, multi-cycle corner sequences and a random run
// checked against a queue-based reference model.
// Expected values come from constants and the model only.
module tb_btb_upd_ctrl;
    localparam int ADDR   = 32;
    localparam int BTB_D  = 32;
    localparam int QDEPTH = 4;
    localparam int IW     = $clog2(BTB_D);
`ifdef BTB_JUMP_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            br_commit_, br_taken_, br_miss_, jump_commit_, jump_miss_, inv_req_;
    logic [ADDR-1:0] com_addr, com_tar_addr;
    logic            upd_stall, sweep_busy;
    logic            btb_br_commit_, btb_br_taken_, btb_br_miss_, btb_jump_commit_, btb_jump_miss_;
    logic [ADDR-1:0] btb_com_addr, btb_com_tar_addr;
    logic            btb_inv_;
    logic [IW-1:0]   btb_inv_idx;

    always #5 clk = ~clk;

    btb_upd_ctrl #(.ADDR(ADDR), .BTB_D(BTB_D), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset),
        .br_commit_(br_commit_), .br_taken_(br_taken_), .br_miss_(br_miss_),
        .jump_commit_(jump_commit_), .jump_miss_(jump_miss_),
        .com_addr(com_addr), .com_tar_addr(com_tar_addr), .inv_req_(inv_req_),
        .upd_stall(upd_stall), .sweep_busy(sweep_busy),
        .btb_br_commit_(btb_br_commit_), .btb_br_taken_(btb_br_taken_), .btb_br_miss_(btb_br_miss_),
        .btb_jump_commit_(btb_jump_commit_), .btb_jump_miss_(btb_jump_miss_),
        .btb_com_addr(btb_com_addr), .btb_com_tar_addr(btb_com_tar_addr),
        .btb_inv_(btb_inv_), .btb_inv_idx(btb_inv_idx)
    );

    typedef struct packed {
        logic bc, bt, bm, jc, jm, inv;
        logic [ADDR-1:0] a, t;
    } stim_t;

    typedef struct packed {
        logic bc, bt, bm, jc, jm, inv, stall, busy;
        logic [IW-1:0]   idx;
        logic [ADDR-1:0] a, t;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
    } vec_t;

    typedef struct {
        bit              jump;
        bit              tk;
        bit              ms;
        logic [ADDR-1:0] a, t;
    } ent_t;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];
    bit   m_sweep;
    int   m_idx;
    obs_t m_exp;
    stim_t idle_s;

    function automatic stim_t mk_stim(input logic bc, bt, bm, jc, jm, inv,
                                      input logic [ADDR-1:0] a, t);
        stim_t s;
        s.bc = bc; s.bt = bt; s.bm = bm; s.jc = jc; s.jm = jm; s.inv = inv; s.a = a; s.t = t;
        return s;
    endfunction

    function automatic obs_t mk_obs(input logic bc, bt, bm, jc, jm,
                                    input logic [ADDR-1:0] a, t);
        obs_t o;
        o.bc = bc; o.bt = bt; o.bm = bm; o.jc = jc; o.jm = jm;
        o.inv = 1'b1; o.stall = 1'b0; o.busy = 1'b0; o.idx = '0; o.a = a; o.t = t;
        return o;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_sweep = 1'b0;
        m_idx   = 0;
        m_exp   = mk_obs(1, 1, 1, 1, 1, '0, '0);
    endfunction

    // Reference: a queue of pending training entries plus a sweep position.
    function automatic void model_step(input stim_t s);
        ent_t e;
        ent_t iss;
        bit   have_iss;
        bit   ev;
        int   sz;
        have_iss = 1'b0;
        iss      = '{default: '0};
        ev       = !s.bc || (!s.jc && (!FILT || !s.jm));
        e.jump   = s.bc;
        e.tk     = s.bc ? 1'b1 : s.bt;
        e.ms     = s.bc ? s.jm : s.bm;
        e.a      = s.a;
        e.t      = s.t;
        sz       = q.size();
        if (!s.inv) begin
            q.delete();
            m_sweep = 1'b1;
            m_idx   = 0;
        end else if (m_sweep) begin
            if (ev && sz < QDEPTH) q.push_back(e);
            if (m_idx == BTB_D - 1) m_sweep = 1'b0;
            else m_idx++;
        end else if (sz > 0) begin
            iss = q.pop_front();
            have_iss = 1'b1;
            if (ev && sz < QDEPTH) q.push_back(e);
        end else if (ev) begin
            iss = e;
            have_iss = 1'b1;
        end
        m_exp.bc = 1'b1; m_exp.bt = 1'b1; m_exp.bm = 1'b1; m_exp.jc = 1'b1; m_exp.jm = 1'b1;
        if (have_iss) begin
            if (iss.jump) begin
                m_exp.jc = 1'b0;
                m_exp.jm = iss.ms;
            end else begin
                m_exp.bc = 1'b0;
                m_exp.bt = iss.tk;
                m_exp.bm = iss.ms;
            end
            m_exp.a = iss.a;
            m_exp.t = iss.t;
        end
        m_exp.inv   = !m_sweep;
        m_exp.busy  = m_sweep;
        m_exp.idx   = IW'(m_idx);
        m_exp.stall = (q.size() == QDEPTH);
    endfunction

    task automatic check_obs(input string name, input obs_t exp, input bit full);
        obs_t act;
        obs_t mask;
        act = {btb_br_commit_, btb_br_taken_, btb_br_miss_, btb_jump_commit_, btb_jump_miss_,
               btb_inv_, upd_stall, sweep_busy, btb_inv_idx, btb_com_addr, btb_com_tar_addr};
        mask = '1;
        if (!full) begin
            if (exp.inv) mask.idx = '0;
            if (exp.bc && exp.jc) begin
                mask.a = '0;
                mask.t = '0;
            end
        end
        n_vec++;
        if (((act ^ exp) & mask) != '0) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h (care %h)", name, $time, act, exp, mask);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        br_commit_   = s.bc;
        br_taken_    = s.bt;
        br_miss_     = s.bm;
        jump_commit_ = s.jc;
        jump_miss_   = s.jm;
        inv_req_     = s.inv;
        com_addr     = s.a;
        com_tar_addr = s.t;
    endtask

    task automatic cyc(input stim_t s, input string name);
        drive(s);
        @(posedge clk);
        model_step(s);
        #1;
        check_obs(name, m_exp, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(idle_s);
        #3;
        model_reset();
        check_obs("reset_values", m_exp, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_sweep_end(input string name);
        int n;
        n = 0;
        while (!btb_inv_ && n < 100) begin
            cyc(idle_s, name);
            n++;
        end
        if (n >= 100) check_int({name, "_timeout"}, n, BTB_D);
    endtask

    vec_t tbl[6];

    initial begin
        int n;
        stim_t s;
        idle_s = mk_stim(1, 1, 1, 1, 1, 1, '0, '0);

        tbl[0] = '{mk_stim(1, 1, 1, 0, 0, 1, 32'hdeadbe74, 32'hcafecafc),
                   mk_obs(1, 1, 1, 0, 0, 32'hdeadbe74, 32'hcafecafc)};
        tbl[1] = '{idle_s, mk_obs(1, 1, 1, 1, 1, '0, '0)};
        tbl[2] = '{mk_stim(0, 0, 1, 1, 1, 1, 32'h00001000, 32'h00002000),
                   mk_obs(0, 0, 1, 1, 1, 32'h00001000, 32'h00002000)};
        tbl[3] = '{mk_stim(0, 1, 0, 1, 1, 1, 32'h00001004, 32'h00003000),
                   mk_obs(0, 1, 0, 1, 1, 32'h00001004, 32'h00003000)};
`ifdef BTB_JUMP_FILTER_EN
        tbl[4] = '{mk_stim(1, 1, 1, 0, 1, 1, 32'h00002000, 32'h00004000),
                   mk_obs(1, 1, 1, 1, 1, '0, '0)};
`else
        tbl[4] = '{mk_stim(1, 1, 1, 0, 1, 1, 32'h00002000, 32'h00004000),
                   mk_obs(1, 1, 1, 0, 1, 32'h00002000, 32'h00004000)};
`endif
        tbl[5] = '{idle_s, mk_obs(1, 1, 1, 1, 1, '0, '0)};

        do_reset();

        // Directed bypass table from idle.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].s);
            @(posedge clk);
            model_step(tbl[i].s);
            #1;
            check_obs($sformatf("table_%0d", i), tbl[i].e, 1'b0);
        end

        // Plain sweep: length and index order.
        cyc(mk_stim(1, 1, 1, 1, 1, 0, '0, '0), "sweep_start");
        n = 0;
        while (!btb_inv_ && n < 100) begin
            check_int("sweep_idx", int'(btb_inv_idx), n);
            check_int("sweep_busy", int'(sweep_busy), 1);
            cyc(idle_s, "sweep_run");
            n++;
        end
        check_int("sweep_len", n, BTB_D);
        check_int("sweep_busy_after", int'(sweep_busy), 0);

        // Five branches during a sweep: four fit, fifth dropped, four drain back-to-back.
        cyc(mk_stim(1, 1, 1, 1, 1, 0, '0, '0), "fill_start");
        for (int i = 0; i < 5; i++) begin
            s = mk_stim(0, 1'(i % 2), 1, 1, 1, 1, ADDR'(32'h100 + 4 * i), ADDR'(32'h900 + i));
            cyc(s, "fill_ev");
            if (i == 3) check_int("fill_stall_at_4", int'(upd_stall), 1);
        end
        wait_sweep_end("fill_wait");
        for (int k = 0; k < 5; k++) begin
            cyc(idle_s, "fill_drain");
            if (k < 4) begin
                check_int("drain_strobe", int'(btb_br_commit_), 0);
                check_int("drain_addr", int'(btb_com_addr), 32'h100 + 4 * k);
            end else begin
                check_int("drain_done", int'(btb_br_commit_), 1);
            end
        end
        check_int("stall_cleared", int'(upd_stall), 0);

        // Restart at index 10 with two entries queued.
        cyc(mk_stim(1, 1, 1, 1, 1, 0, '0, '0), "restart_start");
        cyc(mk_stim(0, 0, 0, 1, 1, 1, 32'h500, 32'h600), "restart_ev");
        cyc(mk_stim(0, 0, 0, 1, 1, 1, 32'h504, 32'h604), "restart_ev");
        n = 0;
        while (btb_inv_idx != IW'(10) && n < 100) begin
            cyc(idle_s, "restart_to10");
            n++;
        end
        check_int("restart_reached10", int'(btb_inv_idx), 10);
        cyc(mk_stim(1, 1, 1, 1, 1, 0, '0, '0), "restart_again");
        n = 0;
        while (!btb_inv_ && n < 100) begin
            check_int("restart_idx", int'(btb_inv_idx), n);
            cyc(idle_s, "restart_run");
            n++;
        end
        check_int("restart_len", n, BTB_D);
        for (int k = 0; k < 3; k++) begin
            cyc(idle_s, "restart_empty");
            check_int("restart_no_issue", int'(btb_br_commit_), 1);
        end

        // Asynchronous reset in the middle of a drain.
        cyc(mk_stim(1, 1, 1, 1, 1, 0, '0, '0), "arst_sweep");
        cyc(mk_stim(0, 0, 1, 1, 1, 1, 32'h700, 32'h800), "arst_ev");
        cyc(mk_stim(0, 1, 0, 1, 1, 1, 32'h704, 32'h804), "arst_ev");
        wait_sweep_end("arst_wait");
        cyc(idle_s, "arst_first_issue");
        check_int("arst_first_issued", int'(btb_br_commit_), 0);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_obs("arst_immediate", m_exp, 1'b1);
        @(posedge clk);
        #1;
        check_obs("arst_held", m_exp, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(idle_s, "arst_after");
            check_int("arst_no_issue", int'(btb_br_commit_), 1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            s = idle_s;
            s.bt = 1'($urandom_range(0, 1));
            s.bm = 1'($urandom_range(0, 1));
            s.jm = 1'($urandom_range(0, 1));
            s.a  = $urandom;
            s.t  = $urandom;
            if (kind == 2) s.bc = 1'b0;
            if (kind == 3) s.jc = 1'b0;
            s.inv = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cyc(s, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
